// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters, active-video and sync decodes,
// sync/blank delay line to line up with mapper latency, and frame bookkeeping.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIPE_DLY  = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        blank_dly,
    output logic        hs,
    output logic        vs,
    output logic        line_tick,
    output logic        frame_tick,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_VIS_C    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_C    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START_C = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END_C   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START_C = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END_C   = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST_C   = 10'(V_TOTAL - 1);

    // {hs, vs, blank} value held by every delay stage out of reset
    localparam logic [2:0]  PIPE_RST   = 3'b110;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 1024", H_TOTAL, V_TOTAL);
    end

    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY=%0d outside 0..7", PIPE_DLY);
    end

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        h_end;
    logic        v_end;
    logic        active;
    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  pipe_in;
    logic [2:0]  pipe_out;
    logic [15:0] frame_cnt;

    assign h_end = (hc == H_LAST_C);
    assign v_end = (vc == V_LAST_C);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (h_end) begin
            hc <= '0;
            vc <= v_end ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign active = ({1'b0, hc} < H_VIS_C) && ({1'b0, vc} < V_VIS_C);
    assign hs_raw = !(({1'b0, hc} >= HS_START_C) && ({1'b0, hc} < HS_END_C));
    assign vs_raw = !(({1'b0, vc} >= VS_START_C) && ({1'b0, vc} < VS_END_C));

    // Reset gates the same-cycle flags so nothing downstream sees a stale raster position.
    assign blank      = !reset && active;
    assign line_tick  = !reset && (hc == 10'd0);
    assign frame_tick = !reset && (hc == 10'd0) && ({1'b0, vc} == V_VIS_C);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign pipe_in = {hs_raw, vs_raw, blank};

    if (PIPE_DLY == 0) begin : g_no_dly
        assign pipe_out = pipe_in;
    end else begin : g_dly
        logic [2:0] stage [PIPE_DLY];

        always_ff @(posedge vga_clk) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    stage[i] <= PIPE_RST;
                end
            end else begin
                stage[0] <= pipe_in;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign pipe_out = stage[PIPE_DLY-1];
    end

    assign hs          = reset || pipe_out[2];
    assign vs          = reset || pipe_out[1];
    assign blank_dly   = !reset && pipe_out[0];
    assign DrawX       = hc;
    assign DrawY       = vc;
    assign frame_count = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three raster configurations checked cycle by cycle against a
// counting model, with the delayed sync/blank outputs checked through a per-lane scoreboard queue.
module tb_vga_timing_gen;
    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       line;
        logic       frame;
    } ras_t;

    // Raster position from the number of clocks since reset release.
    function automatic ras_t model(input int n, hv, hf, hsy, hb, vv, vf, vsy, vb);
        int   ht;
        int   vt;
        int   x;
        int   y;
        ras_t r;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        x = n % ht;
        y = (n / ht) % vt;
        r.x     = 10'(x);
        r.y     = 10'(y);
        r.blank = (x < hv) && (y < vv);
        r.hs    = !((x >= hv + hf) && (x < hv + hf + hsy));
        r.vs    = !((y >= vv + vf) && (y < vv + vf + vsy));
        r.line  = (x == 0);
        r.frame = (x == 0) && (y == vv);
        return r;
    endfunction

    // lane 0: full 640x480, PIPE_DLY=2; lane 1: reduced raster, PIPE_DLY=2; lane 2: tiny raster, PIPE_DLY=0
    localparam int HV [3] = '{640, 64, 4};
    localparam int HF [3] = '{16,  4,  1};
    localparam int HSY[3] = '{96,  8,  1};
    localparam int HB [3] = '{48,  4,  1};
    localparam int VV [3] = '{480, 40, 2};
    localparam int VF [3] = '{10,  2,  1};
    localparam int VSY[3] = '{2,   2,  1};
    localparam int VB [3] = '{33,  3,  1};
    localparam int PD [3] = '{2,   2,  0};

    logic [2:0] rst = 3'b111;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int HT = HV[g] + HF[g] + HSY[g] + HB[g];
        localparam int VT = VV[g] + VF[g] + VSY[g] + VB[g];

        logic [9:0]  draw_x;
        logic [9:0]  draw_y;
        logic        blank;
        logic        blank_dly;
        logic        hs;
        logic        vs;
        logic        line_tick;
        logic        frame_tick;
        logic [15:0] frame_count;

        logic [2:0]  sb[$];
        logic [2:0]  d;
        ras_t        e;
        int          n = 0;
        int          fc = 0;
        int          last_ft = -1;

        vga_timing_gen #(
            .H_VISIBLE(HV[g]), .H_FP(HF[g]), .H_SYNC(HSY[g]), .H_BP(HB[g]),
            .V_VISIBLE(VV[g]), .V_FP(VF[g]), .V_SYNC(VSY[g]), .V_BP(VB[g]),
            .PIPE_DLY(PD[g])
        ) dut (
            .vga_clk    (vga_clk),
            .reset      (rst[g]),
            .DrawX      (draw_x),
            .DrawY      (draw_y),
            .blank      (blank),
            .blank_dly  (blank_dly),
            .hs         (hs),
            .vs         (vs),
            .line_tick  (line_tick),
            .frame_tick (frame_tick),
            .frame_count(frame_count)
        );

        always @(negedge vga_clk) begin
            if (rst[g]) begin
                check($sformatf("L%0d rst blank", g), blank, 1'b0);
                check($sformatf("L%0d rst line_tick", g), line_tick, 1'b0);
                check($sformatf("L%0d rst frame_tick", g), frame_tick, 1'b0);
                check($sformatf("L%0d rst hs", g), hs, 1'b1);
                check($sformatf("L%0d rst vs", g), vs, 1'b1);
                check($sformatf("L%0d rst blank_dly", g), blank_dly, 1'b0);
                sb.delete();
                repeat (PD[g]) sb.push_back(3'b110);
                n = 0;
                fc = 0;
                last_ft = -1;
            end else begin
                e = model(n, HV[g], HF[g], HSY[g], HB[g], VV[g], VF[g], VSY[g], VB[g]);
                check($sformatf("L%0d n=%0d DrawX", g, n), draw_x, e.x);
                check($sformatf("L%0d n=%0d DrawY", g, n), draw_y, e.y);
                check($sformatf("L%0d n=%0d blank", g, n), blank, e.blank);
                check($sformatf("L%0d n=%0d line_tick", g, n), line_tick, e.line);
                check($sformatf("L%0d n=%0d frame_tick", g, n), frame_tick, e.frame);
                check($sformatf("L%0d n=%0d frame_count", g, n), frame_count, 16'(fc));
                sb.push_back({e.hs, e.vs, e.blank});
                d = sb.pop_front();
                check($sformatf("L%0d n=%0d hs", g, n), hs, d[2]);
                check($sformatf("L%0d n=%0d vs", g, n), vs, d[1]);
                check($sformatf("L%0d n=%0d blank_dly", g, n), blank_dly, d[0]);
                if (frame_tick) begin
                    if (last_ft >= 0) begin
                        check($sformatf("L%0d frame_tick gap", g), n - last_ft, HT * VT);
                    end
                    last_ft = n;
                end
                if (e.frame) fc++;
                n++;
            end
        end
    end

    initial begin
        repeat (3) @(posedge vga_clk);
        #1 rst = 3'b000;
        // lane 1 raster is 80x47: cycle 1630 sits at DrawX=30, DrawY=20
        repeat (1630) @(posedge vga_clk);
        #1 rst[1] = 1'b1;
        @(posedge vga_clk);
        #1 rst[1] = 1'b0;
        repeat (2 * 3760 + 100) @(posedge vga_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
